// File: rtl/clock_pkg.sv
// Shared constants for the 7-segment scan readback path: segment codes,
// anode digit indices and the scan FSM encoding.
package clock_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [1:0] IDX_H1 = 2'd3;
    localparam logic [1:0] IDX_H2 = 2'd2;
    localparam logic [1:0] IDX_M1 = 2'd1;
    localparam logic [1:0] IDX_M2 = 2'd0;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } scan_state_e;

    typedef enum logic [1:0] {
        AN_BLANK,
        AN_ONE,
        AN_MULTI
    } anode_class_e;

    function automatic anode_class_e anode_class(input logic [3:0] an);
        case (an)
            4'b1111:                            return AN_BLANK;
            4'b0111, 4'b1011, 4'b1101, 4'b1110: return AN_ONE;
            default:                            return AN_MULTI;
        endcase
    endfunction

    // Only meaningful when anode_class() reports AN_ONE.
    function automatic logic [1:0] anode_index(input logic [3:0] an);
        case (an)
            4'b0111: return IDX_H1;
            4'b1011: return IDX_H2;
            4'b1101: return IDX_M1;
            default: return IDX_M2;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Inverse of the display encoder: active-low 7-segment pattern to a decimal
// digit, with valid low for any pattern the encoder never produces.
module seg7_to_bcd
    import clock_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       valid
);

    always_comb begin
        value = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Readback monitor for the multiplexed 4-digit display bus: recovers H1..M2,
// range-checks them and publishes whole frames only.
module seg_scan_decoder
    import clock_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segments,
    input  logic [3:0] anode_active,
    output logic [1:0] H1,
    output logic [3:0] H2,
    output logic [2:0] M1,
    output logic [3:0] M2,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       stalled
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT_CYCLES);

    logic [6:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_p_q, seg_p_d;
    logic [3:0]       an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_p_q, an_p_d;
    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [1:0]       sh_h1_q, sh_h1_d, h1_q, h1_d;
    logic [3:0]       sh_h2_q, sh_h2_d, h2_q, h2_d;
    logic [2:0]       sh_m1_q, sh_m1_d, m1_q, m1_d;
    logic [3:0]       sh_m2_q, sh_m2_d, m2_q, m2_d;
    logic             fv_q, fv_d, err_q, err_d, stalled_q, stalled_d;

    logic [3:0]   dec_val;
    logic         dec_ok;
    logic         anode_chg, any_chg, sample_bad;
    anode_class_e an_cls;
    logic [1:0]   an_idx;

    seg7_to_bcd u_dec (
        .seg   (seg_s2_q),
        .value (dec_val),
        .valid (dec_ok)
    );

    assign anode_chg = (an_s2_q != an_p_q);
    assign any_chg   = anode_chg || (seg_s2_q != seg_p_q);
    assign an_cls    = anode_class(an_s2_q);
    assign an_idx    = anode_index(an_s2_q);

    // Hours may not exceed 23: the H1/H2 pair is checked against whichever
    // half of it is already held in the shadow.
    always_comb begin
        sample_bad = !dec_ok;
        case (an_idx)
            IDX_H1: if (dec_val > 4'd2 ||
                        (dec_val == 4'd2 && mask_q[IDX_H2] && sh_h2_q > 4'd3))
                        sample_bad = 1'b1;
            IDX_H2: if (mask_q[IDX_H1] && sh_h1_q == 2'd2 && dec_val > 4'd3)
                        sample_bad = 1'b1;
            IDX_M1: if (dec_val > 4'd5) sample_bad = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        seg_s1_d  = segments;
        seg_s2_d  = seg_s1_q;
        seg_p_d   = seg_s2_q;
        an_s1_d   = anode_active;
        an_s2_d   = an_s1_q;
        an_p_d    = an_s2_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        sh_h1_d   = sh_h1_q;
        sh_h2_d   = sh_h2_q;
        sh_m1_d   = sh_m1_q;
        sh_m2_d   = sh_m2_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        m1_d      = m1_q;
        m2_d      = m2_q;
        fv_d      = 1'b0;
        err_d     = err_q;
        stalled_d = stalled_q && !anode_chg;

        case (state_q)
            WAIT: begin
                if (any_chg) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    stalled_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (any_chg) begin
                    cnt_d = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    case (an_cls)
                        AN_ONE:   state_d = SAMPLE;
                        AN_BLANK: state_d = WAIT;
                        default: begin
                            err_d   = 1'b1;
                            mask_d  = 4'b0000;
                            state_d = WAIT;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                cnt_d = '0;
                // A change landing in this very cycle means the value is not settled.
                if (any_chg) begin
                    state_d = SETTLE;
                end else begin
                    state_d = WAIT;
                    if (sample_bad) begin
                        err_d  = 1'b1;
                        mask_d = 4'b0000;
                    end else begin
                        mask_d[an_idx] = 1'b1;
                        case (an_idx)
                            IDX_H1:  sh_h1_d = dec_val[1:0];
                            IDX_H2:  sh_h2_d = dec_val;
                            IDX_M1:  sh_m1_d = dec_val[2:0];
                            default: sh_m2_d = dec_val;
                        endcase
                    end
                end
            end
            default: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
        endcase

        if (mask_d == 4'b1111) begin
            h1_d   = sh_h1_d;
            h2_d   = sh_h2_d;
            m1_d   = sh_m1_d;
            m2_d   = sh_m2_d;
            fv_d   = 1'b1;
            mask_d = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q  <= '0;
            seg_s2_q  <= '0;
            seg_p_q   <= '0;
            an_s1_q   <= '0;
            an_s2_q   <= '0;
            an_p_q    <= '0;
            state_q   <= WAIT;
            cnt_q     <= '0;
            mask_q    <= '0;
            sh_h1_q   <= '0;
            sh_h2_q   <= '0;
            sh_m1_q   <= '0;
            sh_m2_q   <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            m1_q      <= '0;
            m2_q      <= '0;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            seg_s1_q  <= seg_s1_d;
            seg_s2_q  <= seg_s2_d;
            seg_p_q   <= seg_p_d;
            an_s1_q   <= an_s1_d;
            an_s2_q   <= an_s2_d;
            an_p_q    <= an_p_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            sh_h1_q   <= sh_h1_d;
            sh_h2_q   <= sh_h2_d;
            sh_m1_q   <= sh_m1_d;
            sh_m2_q   <= sh_m2_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
            m1_q      <= m1_d;
            m2_q      <= m2_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
            stalled_q <= stalled_d;
        end
    end

    assign H1          = h1_q;
    assign H2          = h2_q;
    assign M1          = m1_q;
    assign M2          = m2_q;
    assign frame_valid = fv_q;
    assign seg_err     = err_q;
    assign stalled     = stalled_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: digit-level reference model (frame = last good
// value per digit, hours <= 23) against directed scans and random traffic.
module tb_seg_scan_decoder;

    localparam int SETTLE = 8;
    localparam int TMO    = 400;
    localparam int HOLD   = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] segments;
    logic [3:0] anode_active;
    logic [1:0] H1;
    logic [3:0] H2;
    logic [2:0] M1;
    logic [3:0] M2;
    logic       frame_valid, seg_err, stalled;

    seg_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (21)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .segments     (segments),
        .anode_active (anode_active),
        .H1           (H1),
        .H2           (H2),
        .M1           (M1),
        .M2           (M2),
        .frame_valid  (frame_valid),
        .seg_err      (seg_err),
        .stalled      (stalled)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    int checks = 0;
    int errors = 0;

    // reference model state: shadows indexed by anode bit (3=H1 .. 0=M2)
    int       m_sh [4];
    bit [3:0] m_mask;
    int       e_h1, e_h2, e_m1, e_m2, e_fv;
    bit       e_err, e_stall;

    int       fv_seen = 0;
    bit       chk_req = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (seg_tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mask = 4'b0;
        for (int i = 0; i < 4; i++) m_sh[i] = 0;
        e_h1 = 0; e_h2 = 0; e_m1 = 0; e_m2 = 0;
        e_fv = 0; e_err = 1'b0; e_stall = 1'b0;
    endtask

    // One settled digit as seen on the bus.
    task automatic model_digit(input logic [3:0] an, input logic [6:0] p);
        int idx, v;
        bit bad;
        if (an == 4'hF) return;
        if ($countones(~an) > 1) begin
            e_err = 1'b1; m_mask = 4'b0; return;
        end
        idx = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
        v = decode(p);
        bad = (v < 0);
        if (idx == 3 && v > 2) bad = 1'b1;
        if (idx == 1 && v > 5) bad = 1'b1;
        if (idx == 3 && m_mask[2] && 10 * v + m_sh[2] > 23) bad = 1'b1;
        if (idx == 2 && m_mask[3] && 10 * m_sh[3] + v > 23) bad = 1'b1;
        if (bad) begin
            e_err = 1'b1; m_mask = 4'b0; return;
        end
        m_sh[idx] = v;
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
            e_h1 = m_sh[3]; e_h2 = m_sh[2]; e_m1 = m_sh[1]; e_m2 = m_sh[0];
            e_fv++;
            m_mask = 4'b0;
        end
    endtask

    // Compare process: outputs against the model at every check point, plus a
    // per-cycle guard that outputs never move without frame_valid.
    initial begin
        logic [12:0] prev_out;
        logic        rst_d;
        prev_out = '0;
        rst_d    = 1'b1;
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) fv_seen++;
            if (rst === 1'b0 && rst_d === 1'b0 && {H1, H2, M1, M2} != prev_out)
                check("update_without_frame_valid", int'(frame_valid), 1);
            prev_out = {H1, H2, M1, M2};
            rst_d    = rst;
            if (chk_req) begin
                check("H1", int'(H1), e_h1);
                check("H2", int'(H2), e_h2);
                check("M1", int'(M1), e_m1);
                check("M2", int'(M2), e_m2);
                check("seg_err", int'(seg_err), int'(e_err));
                check("stalled", int'(stalled), int'(e_stall));
                check("frame_valid_count", fv_seen, e_fv);
                fv_seen = 0;
            end
        end
    end

    task automatic do_check();
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
        e_fv = 0;
    endtask

    task automatic apply(input logic [3:0] an, input logic [6:0] p);
        anode_active = an;
        segments     = p;
        repeat (HOLD) @(negedge clk);
        #1;
        e_stall = 1'b0;
        model_digit(an, p);
        do_check();
    endtask

    task automatic hold_check(input int n, input bit st);
        repeat (n) @(negedge clk);
        #1;
        e_stall = st;
        do_check();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        anode_active = 4'hF;
        segments     = 7'h7F;
        repeat (3) @(negedge clk);
        #1;
        model_reset();
        do_check();
        rst = 1'b0;
        hold_check(HOLD, 1'b0);
    endtask

    task automatic rand_step();
        logic [3:0] an;
        logic [6:0] p;
        int r, idx, lim;
        r   = $urandom_range(0, 99);
        idx = $urandom_range(0, 3);
        if (r < 5)       an = 4'hF;
        else if (r < 10) an = 4'($urandom_range(0, 15));
        else begin
            an = 4'hF;
            an[idx] = 1'b0;
        end
        if (an == anode_active) an = (an == 4'hF) ? 4'b1110 : 4'hF;
        lim = (idx == 3) ? 2 : (idx == 1) ? 5 : (idx == 2) ? 3 : 9;
        r = $urandom_range(0, 99);
        if (r < 6)       p = 7'($urandom_range(0, 127));
        else if (r < 16) p = seg_tbl[$urandom_range(0, 9)];
        else             p = seg_tbl[$urandom_range(0, lim)];
        apply(an, p);
    endtask

    initial begin
        rst          = 1'b1;
        anode_active = 4'hF;
        segments     = 7'h7F;
        model_reset();
        do_reset();

        // plain scan 1-2-3-4
        apply(4'b0111, seg_tbl[1]);
        apply(4'b1011, seg_tbl[2]);
        apply(4'b1101, seg_tbl[3]);
        apply(4'b1110, seg_tbl[4]);
        check("lit_scan_H1", int'(H1), 1);
        check("lit_scan_H2", int'(H2), 2);
        check("lit_scan_M1", int'(M1), 3);
        check("lit_scan_M2", int'(M2), 4);
        check("lit_scan_err", int'(seg_err), 0);

        // glitching M2 never samples; the settled 9 does
        apply(4'b0111, seg_tbl[1]);
        apply(4'b1011, seg_tbl[5]);
        apply(4'b1101, seg_tbl[4]);
        anode_active = 4'b1110;
        for (int i = 0; i < 7; i++) begin
            segments = (i % 2 == 0) ? seg_tbl[8] : seg_tbl[1];
            repeat (3) @(negedge clk);
            #1;
        end
        apply(4'b1110, seg_tbl[9]);
        check("lit_glitch_M2", int'(M2), 9);
        check("lit_glitch_H2", int'(H2), 5);

        // 24 hours is out of range; outputs keep 15:49
        apply(4'b0111, seg_tbl[2]);
        apply(4'b1011, seg_tbl[4]);
        apply(4'b1101, seg_tbl[0]);
        apply(4'b1110, seg_tbl[0]);
        check("lit_range_err", int'(seg_err), 1);
        check("lit_range_H1", int'(H1), 1);

        do_reset();
        apply(4'b0011, seg_tbl[1]);
        check("lit_multi_err", int'(seg_err), 1);

        // undecodable H2 drops the partial frame; 09:59 then commits
        do_reset();
        apply(4'b0111, seg_tbl[0]);
        apply(4'b1011, 7'b1111111);
        apply(4'b0111, seg_tbl[0]);
        apply(4'b1011, seg_tbl[9]);
        apply(4'b1101, seg_tbl[5]);
        apply(4'b1110, seg_tbl[9]);
        check("lit_recover_H2", int'(H2), 9);
        check("lit_recover_M1", int'(M1), 5);

        // stall: frozen bus, then an anode change clears it
        apply(4'b0111, seg_tbl[1]);
        hold_check(TMO - 60, 1'b0);
        hold_check(120, 1'b1);
        apply(4'b1011, seg_tbl[2]);

        // reset after three digits, then a full 23:59
        do_reset();
        apply(4'b0111, seg_tbl[1]);
        apply(4'b1011, seg_tbl[1]);
        apply(4'b1101, seg_tbl[1]);
        do_reset();
        apply(4'b0111, seg_tbl[2]);
        apply(4'b1011, seg_tbl[3]);
        apply(4'b1101, seg_tbl[5]);
        apply(4'b1110, seg_tbl[9]);
        check("lit_post_rst_H1", int'(H1), 2);
        check("lit_post_rst_M2", int'(M2), 9);
        check("lit_post_rst_err", int'(seg_err), 0);

        for (int n = 0; n < 300; n++) begin
            if (n == 150) do_reset();
            rand_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
